// File: rtl/ub_skew_feeder.sv
// Unified-buffer read sequencer: streams consecutive BRAM rows and skews lane i
// by i cycles to form the diagonal wavefront the systolic array expects.
//
// state  | meaning
// IDLE   | waiting for start
// READ   | issuing one BRAM row read per cycle
// DRAIN  | reads finished, waiting for the last lane to leave the skew
// DONE   | one-cycle completion pulse; a new start is accepted here too
module ub_skew_feeder #(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [ADDR_WIDTH:0]         row_count,
  output logic                        busy,
  output logic                        done,
  output logic                        bram_enb,
  output logic [ADDR_WIDTH-1:0]       bram_addrb,
  input  logic [LANES*DATA_WIDTH-1:0] bram_doutb,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_valid
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             issue_v;

  assign busy = (state == ST_READ) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  // cnt: rows left to issue in READ, lane beats left to drain in DRAIN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bram_enb   <= 1'b0;
      bram_addrb <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start) begin
            if (row_count != '0) begin
              state      <= ST_READ;
              bram_enb   <= 1'b1;
              bram_addrb <= base_addr;
              cnt        <= row_count - CNT_W'(1);
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          if (cnt == '0) begin
            state    <= ST_DRAIN;
            bram_enb <= 1'b0;
            cnt      <= CNT_W'(LANES - 1);
          end else begin
            cnt        <= cnt - CNT_W'(1);
            bram_addrb <= bram_addrb + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // BRAM output register is the capture stage; issue_v marks when it holds a requested row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) issue_v <= 1'b0;
    else          issue_v <= bram_enb;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == 0) begin : g_l0
      assign out_valid[0]            = issue_v;
      assign out_data[DATA_WIDTH-1:0] = issue_v ? bram_doutb[DATA_WIDTH-1:0] : '0;
    end else begin : g_ln
      logic [DATA_WIDTH-1:0] sd [1:i];
      logic [i:1]            sv;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 1; s <= i; s++) sd[s] <= '0;
          sv <= '0;
        end else begin
          sd[1] <= bram_doutb[i*DATA_WIDTH +: DATA_WIDTH];
          sv[1] <= issue_v;
          for (int s = 2; s <= i; s++) begin
            sd[s] <= sd[s-1];
            sv[s] <= sv[s-1];
          end
        end
      end

      assign out_valid[i]                       = sv[i];
      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = sv[i] ? sd[i] : '0;
    end
  end

endmodule

// File: tb/tb_ub_skew_feeder.sv
// Scoreboard bench for ub_skew_feeder: a behavioural BRAM feeds the DUT and a
// negedge monitor matches reads, lane beats and done pulses against queued expectations.
module tb_ub_skew_feeder;
  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int W     = LANES * DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   row_count;
  logic          busy, done, bram_enb;
  logic [AW-1:0] bram_addrb;
  logic [W-1:0]  bram_doutb = '0;
  logic [W-1:0]  out_data;
  logic [LANES-1:0] out_valid;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int nbeats = 0;

  logic [127:0] addr_q[$];
  logic [127:0] beat_q[$];
  logic [127:0] done_q[$];

  ub_skew_feeder #(.LANES(LANES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .row_count(row_count), .busy(busy), .done(done), .bram_enb(bram_enb),
    .bram_addrb(bram_addrb), .bram_doutb(bram_doutb), .out_data(out_data),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] lane_val(input int a, input int i);
    return 8'((a * 16 + i + (a >> 4) * 7) & 255);
  endfunction

  function automatic logic [W-1:0] word_of(input int a);
    logic [W-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*DW +: DW] = lane_val(a, i);
    return w;
  endfunction

  // One-cycle-latency BRAM read port
  always @(posedge clk) if (bram_enb) bram_doutb <= word_of(int'(bram_addrb));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [127:0] mask_w;
  logic [127:0] got_w;

  always @(negedge clk) begin
    if (bram_enb) begin
      got_w = {88'd0, 32'(cyc), bram_addrb};
      if (addr_q.size() != 0) check("rd_addr", got_w, addr_q.pop_front());
      else                    check("extra_rd", got_w, '1);
    end
    mask_w = '0;
    for (int i = 0; i < LANES; i++) begin
      if (out_valid[i]) begin
        mask_w[i*DW +: DW] = '1;
        got_w = {80'd0, 32'(cyc), 8'(i), out_data[i*DW +: DW]};
        nbeats++;
        if (beat_q.size() != 0) check("beat", got_w, beat_q.pop_front());
        else                    check("extra_beat", got_w, '1);
      end
    end
    check("gated", {{(128-W){1'b0}}, out_data} & ~mask_w, '0);
    if (done) begin
      got_w = 128'(cyc);
      if (done_q.size() != 0) check("done_cyc", got_w, done_q.pop_front());
      else                    check("extra_done", got_w, '1);
    end
  end

  // Called at a negedge; drives start for one cycle and returns at the cycle-0 negedge
  task automatic start_run(input int base, input int r);
    int c0;
    start     = 1'b1;
    base_addr = base[AW-1:0];
    row_count = r[AW:0];
    c0 = cyc + 1;
    nbeats = 0;
    for (int k = 0; k < r; k++)
      addr_q.push_back({88'd0, 32'(c0 + k), 8'((base + k) % 256)});
    for (int c = 1; c < r + LANES; c++)
      for (int i = 0; i < LANES; i++) begin
        int k;
        k = c - 1 - i;
        if (k >= 0 && k < r)
          beat_q.push_back({80'd0, 32'(c0 + c), 8'(i), lane_val((base + k) % 256, i)});
      end
    done_q.push_back(128'((r != 0) ? c0 + r + LANES : c0));
    @(negedge clk);
    start = 1'b0;
    check("busy_c0", 128'(busy), 128'(r != 0));
    check("enb_c0", 128'(bram_enb), 128'(r != 0));
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((addr_q.size() + beat_q.size() + done_q.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drained", 128'(addr_q.size() + beat_q.size() + done_q.size()), '0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    start = 1'b0;
    base_addr = '0;
    row_count = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctl", 128'({busy, done, bram_enb, bram_addrb, out_valid}), '0);
    check("rst_data", 128'(out_data), '0);
    reset_n = 1'b1;
    @(negedge clk);

    start_run(0, 4);
    wait_idle(100);
    check("beats_r4", 128'(nbeats), 128'(64));

    start_run(254, 4);
    wait_idle(100);
    check("beats_wrap", 128'(nbeats), 128'(64));

    start_run(0, 0);
    wait_idle(100);
    check("beats_r0", 128'(nbeats), '0);

    // start while busy must be ignored
    start_run(10, 8);
    repeat (5) @(negedge clk);
    start = 1'b1; base_addr = 8'd99; row_count = 9'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100);
    check("beats_ign", 128'(nbeats), 128'(128));

    // back-to-back: restart in the done cycle
    start_run(20, 8);
    repeat (24) @(negedge clk);
    check("done_c24", 128'({done, busy}), 128'(2'b10));
    start_run(40, 5);
    wait_idle(100);

    // async reset in the middle of READ
    start_run(0, 8);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("arst_ctl", 128'({busy, done, bram_enb, bram_addrb, out_valid}), '0);
    check("arst_data", 128'(out_data), '0);
    addr_q.delete();
    beat_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    start_run(100, 2);
    wait_idle(100);
    check("beats_post", 128'(nbeats), 128'(32));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/ub_skew_feeder.md
# ub_skew_feeder

Read-side sequencer that sits directly downstream of the unified-buffer BRAM and feeds the systolic array. On a start command it streams a block of consecutive BRAM rows out of the buffer. It splits each row into LANES byte lanes and emits lane i delayed by i cycles, producing the diagonal wavefront the array's row inputs require. It drives the BRAM read port (enb/addrb) and consumes doutb; the write port is untouched.

## Interface
- LANES, 16, number of array rows / byte lanes per BRAM word
- DATA_WIDTH, 8, bits per lane; BRAM word width = LANES*DATA_WIDTH
- ADDR_WIDTH, 8, BRAM read address width
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; sampled only when busy=0
- base_addr  in  ADDR_WIDTH  first row address, latched with start
- row_count  in  ADDR_WIDTH+1  rows to stream, latched with start
- busy  out  1  high from the start-accept edge until done
- done  out  1  one-cycle pulse after the final lane beat
- bram_enb  out  1  BRAM read enable
- bram_addrb  out  ADDR_WIDTH  BRAM read address
- bram_doutb  in  LANES*DATA_WIDTH  BRAM read data; valid at the rising edge after enb/addr are presented
- out_data  out  LANES*DATA_WIDTH  skewed lane data; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  LANES  per-lane valid; bit i qualifies lane i

## Operation
- FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches base_addr and row_count.
  - row_count!=0 goes to READ; row_count=0 goes to DONE.
- READ:
  - Asserts bram_enb with bram_addrb = base_addr + k for k = 0..row_count-1, one row per cycle.
  - Address addition is modulo 2^ADDR_WIDTH (wraps past the top row).
  - After the last issue, goes to DRAIN.
- Capture: a 1-cycle issue-valid delay marks when bram_doutb holds the requested row. The captured row enters the skew pipeline.
- Skew: lane i passes through i register stages beyond the capture register; its valid bit travels alongside it. out_valid[0] therefore tracks captured rows directly.
- When out_valid[i]=0, lane i of out_data is forced to 0.
- DRAIN: bram_enb=0. Holds until the last row's lane LANES-1 has been emitted, then goes to DONE.
- DONE: done=1 for one cycle, busy=0, then returns to IDLE.
- start while busy=1 is ignored and has no side effects.
- row_count > 2^ADDR_WIDTH re-reads wrapped addresses; no error is flagged.
- Reset (async, any state): state=IDLE; pipelines and valids cleared; all outputs 0.

## Timing
- Reset values: busy=0, done=0, bram_enb=0, bram_addrb=0, out_data=0, out_valid=0.
- Cycle 0 is the cycle after the edge that samples start:
  - busy=1, bram_enb=1, bram_addrb=base_addr.
  - bram_enb/addrb are registered outputs.
- Row k is issued in cycle k, for k < R (R = row_count).
- Lane i of row k is visible in cycle 1+k+i with out_valid[i]=1.
- First output beat is in cycle 1 (lane 0, row 0). Last output beat is in cycle R+LANES-1 (lane LANES-1, row R-1).
- In steady state, lane i carries valid data for exactly R consecutive cycles.
- done=1 and busy=0 in cycle R+LANES. A start sampled at the edge ending that cycle is accepted.
- For R=0: done=1 in cycle 0, and no bram_enb or out_valid is ever asserted.
- Throughput: one row per cycle with no bubbles. Latency from start to the first beat is 2 edges.

## Test plan
- Load rows 0..3 with word[i]=row*16+i. Start with base=0, R=4.
  - Required: lane i shows row*16+i in cycles 1+row+i.
  - Required: done in cycle 20, and exactly 64 valid lane beats.
- Base=254, R=4:
  - Required: bram_addrb sequence 254, 255, 0, 1; output data matches those rows in order.
- R=0:
  - Required: done in cycle 0; bram_enb, out_valid and out_data stay 0 throughout.
- Start pulse during busy (cycle 5 of an R=8 run):
  - Required: the run completes unchanged, with done in cycle 24 only.
  - Then start again in cycle 24: required cycle 0 of the new run is cycle 25, and both runs are correct.
- Deassert reset_n asynchronously mid-READ (cycle 3, R=8):
  - Required: all outputs are 0 immediately, and no done pulse occurs.
  - After release, a fresh R=2 run behaves nominally.
